serial_deserializer: RTL
========================

# serial_deserializer

Parametrised serial-to-parallel converter, successor to the fixed 8-bit converter in the sequential lab set. It accepts a framed serial bit stream with per-bit qualification and produces WIDTH-bit words. Output bit order is selectable. Each word is held in an output register behind a valid/ready handshake. A sticky overrun flag records words dropped because the consumer did not accept in time.

## Interface
- WIDTH, 8: word width in bits, legal range 2..32.
- MSB_FIRST, 0: 0 places the first received bit in out_data[0]; 1 places it in out_data[WIDTH-1].
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_start  in  1  frame start; sampled each cycle.
- d  in  1  serial data; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies d this cycle.
- out_ready  in  1  consumer accepts out_data.
- clr_overrun  in  1  clears overrun.
- out_data  out  WIDTH  last completed word, registered.
- out_valid  out  1  out_data holds an unaccepted word.
- end_conversion  out  1  one-cycle pulse when a word is loaded into out_data.
- busy  out  1  frame in progress (state SHIFT).
- overrun  out  1  sticky: a completed word was dropped.

## Operation
- Reset (reset_n=0, asynchronous) sets state IDLE, bit counter 0, shift register 0, out_data 0, out_valid 0, end_conversion 0, busy 0, overrun 0.
- States:
  - IDLE: bits are ignored.
  - SHIFT: collecting bits.
- serial_start=1 in any state begins a new frame in the same cycle.
  - Any partial frame is discarded, and the counter is forced to 0.
  - If bit_valid=1 in that cycle, d is bit 0 of the new frame.
  - The start cycle therefore behaves exactly like a SHIFT cycle with counter 0.
- Bit acceptance (SHIFT, or start cycle) when bit_valid=1:
  - MSB_FIRST=0: shift right, with d entering bit WIDTH-1.
  - MSB_FIRST=1: shift left, with d entering bit 0.
  - The counter then increments.
- Cycles with bit_valid=0 hold the shift register and counter (stall), with no timeout.
- Word completion: a bit is accepted while counter==WIDTH-1.
  - The completed word is shift_next, i.e. it includes the current d.
  - The counter returns to 0 and the state goes to IDLE, unless serial_start=1 in the same cycle, in which case the start rule governs.
- Load rule on completion:
  - If out_valid=0, or out_ready=1 this cycle: out_data <= word, out_valid <= 1, end_conversion pulses 1 for the next cycle.
  - If out_valid=1 and out_ready=0: the word is dropped, out_data is unchanged, and overrun <= 1.
- Handshake: at a rising edge with out_valid=1 and out_ready=1, the word is consumed and out_valid <= 0, unless a load happens at the same edge. A load wins: out_valid stays 1 with the new data.
- out_data is stable while out_valid=1 and out_ready=0.
- overrun:
  - Cleared by clr_overrun.
  - A set event in the same cycle as clr_overrun wins, so overrun=1.
- Counter width is $clog2(WIDTH) bits. Counter values WIDTH and above are unreachable.

## Timing
- Latency: the last bit is accepted in cycle k. out_valid, out_data and end_conversion are all visible in cycle k+1.
- Minimum frame time is WIDTH cycles. Back-to-back frames are allowed: serial_start may coincide with the last-bit cycle of the previous frame, and no dead cycle is needed.
- With out_ready held at 1, the sustained rate is one word per WIDTH bit_valid cycles with no overrun.
- busy rises the cycle after serial_start and falls the cycle after completion.
- Reset mid-frame or mid-handshake drops all state immediately, without waiting for the clock edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package serial_pkg holds:
  - the state enum deser_state_t {IDLE, SHIFT};
  - the WIDTH range limits;
  - the counter width function.
- One sub-module is natural: serial_shift_core. It contains the shift register and counter, with inputs load_start, bit_valid and d, and outputs word and word_done, and is parametrised on WIDTH and MSB_FIRST.
- The top level owns the FSM, the output register, the handshake and overrun.

## Test plan
- WIDTH=8, MSB_FIRST=0, out_ready=1: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=0x4D, out_valid=1, and end_conversion pulses once, 1 cycle after the last bit.
- Same bits with MSB_FIRST=1 -> out_data=0xB2. Drop bit_valid for 3 cycles mid-frame -> same result, completion delayed exactly 3 cycles.
- out_ready=0: send 0x4D, then a second frame 0xFF -> out_data stays 0x4D and overrun=1. clr_overrun -> overrun=0. Then out_ready=1 for one cycle -> out_valid=0.
- Back-to-back: serial_start coincides with the last bit of 0x4D, next frame 0x01 -> two loads WIDTH cycles apart, no lost bits. Restart after 4 bits -> partial bits discarded and the next 8 bits form the word.
- WIDTH=5: bits 1,1,0,0,1 -> out_data=0x13. Assert reset_n=0 mid-frame and mid-handshake -> all outputs 0 immediately, and the next full frame converts correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial deserializer family.
// Holds the FSM state type, the legal WIDTH range and the counter sizing.
package serial_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } deser_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Bits needed to count 0..w-1, never less than one.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_shift_core.sv
// Shift register and bit counter for one serial frame.
// Reports the completed word combinationally in the cycle its last bit arrives.
module serial_shift_core
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_start,
   input  logic             bit_valid,
   input  logic             d,
   output logic [WIDTH-1:0] word,
   output logic             word_done
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_reg, cnt_next, cnt_base;
   logic [WIDTH-1:0] shift_reg, shift_next, shift_base, shifted;

   // A start discards the partial frame, so the cycle acts as bit 0 of a fresh one.
   assign cnt_base   = load_start ? '0 : cnt_reg;
   assign shift_base = load_start ? '0 : shift_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_in
               assign shifted[gi] = d;
            end else begin : g_mv
               assign shifted[gi] = shift_base[gi-1];
            end
         end else begin : g_right
            if (gi == WIDTH - 1) begin : g_in
               assign shifted[gi] = d;
            end else begin : g_mv
               assign shifted[gi] = shift_base[gi+1];
            end
         end
      end
   endgenerate

   always_comb begin
      shift_next = shift_base;
      cnt_next   = cnt_base;
      word_done  = 1'b0;
      if (bit_valid) begin
         shift_next = shifted;
         word_done  = (cnt_base == LAST);
         cnt_next   = word_done ? '0 : cnt_base + CW'(1);
      end
   end

   assign word = shift_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg   <= '0;
         shift_reg <= '0;
      end else begin
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel converter with registered valid/ready output
// and a sticky overrun flag for words the consumer failed to take.
module serial_deserializer
   import serial_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             serial_start,
   input  logic             d,
   input  logic             bit_valid,
   input  logic             out_ready,
   input  logic             clr_overrun,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             end_conversion,
   output logic             busy,
   output logic             overrun
);

   deser_state_t     state_reg, state_next;
   logic [WIDTH-1:0] out_data_reg;
   logic             out_valid_reg, eoc_reg, overrun_reg;
   logic             take_bit, word_done, load, drop;
   logic [WIDTH-1:0] word;

   // Bits only count while a frame is open or being opened this cycle.
   assign take_bit = bit_valid & (serial_start | (state_reg == SHIFT));

   serial_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_start (serial_start),
      .bit_valid  (take_bit),
      .d          (d),
      .word       (word),
      .word_done  (word_done)
   );

   always_comb begin
      state_next = state_reg;
      if (serial_start) begin
         state_next = SHIFT;
      end else if (word_done) begin
         state_next = IDLE;
      end
   end

   // A word is only dropped when the held one is still unaccepted at this edge.
   assign load = word_done & (~out_valid_reg | out_ready);
   assign drop = word_done & out_valid_reg & ~out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         eoc_reg       <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         eoc_reg   <= load;
         if (load) begin
            out_data_reg  <= word;
            out_valid_reg <= 1'b1;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (drop) begin
            overrun_reg <= 1'b1;
         end else if (clr_overrun) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign out_data       = out_data_reg;
   assign out_valid      = out_valid_reg;
   assign end_conversion = eoc_reg;
   assign busy           = (state_reg == SHIFT);
   assign overrun        = overrun_reg;

endmodule
